// File: rtl/arp_pkg.sv
// Shared ARP definitions: state encoding, fixed Ethernet/ARP field values
// and byte-select helpers used by the ARP receive and transmit paths.
package arp_pkg;

  localparam int unsigned STATE_W = 5;
  localparam int unsigned CNT_W   = 6;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 5'b00001,
    PRE_DATA = 5'b00010,
    ETH_HEAD = 5'b00100,
    ARP_DATA = 5'b01000,
    RX_END   = 5'b10000
  } arp_state_e;

  localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
  localparam logic [15:0] ARP_HTYPE    = 16'h0001;
  localparam logic [15:0] ARP_PTYPE    = 16'h0800;
  localparam logic [7:0]  ARP_HLEN     = 8'h06;
  localparam logic [7:0]  ARP_PLEN     = 8'h04;
  localparam logic [7:0]  ARP_OP_REQ   = 8'h01;
  localparam logic [7:0]  ARP_OP_REP   = 8'h02;
  localparam logic [7:0]  PREAMBLE     = 8'h55;
  localparam logic [7:0]  SFD          = 8'hD5;

  // Fixed ARP header bytes 0..6 (HTYPE, PTYPE, HLEN, PLEN, opcode high byte).
  function automatic logic [7:0] arp_hdr_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return ARP_HTYPE[15:8];
      3'd1:    return ARP_HTYPE[7:0];
      3'd2:    return ARP_PTYPE[15:8];
      3'd3:    return ARP_PTYPE[7:0];
      3'd4:    return ARP_HLEN;
      3'd5:    return ARP_PLEN;
      default: return 8'h00;
    endcase
  endfunction

  // Byte idx of a MAC address in wire order (byte 0 is the MSB).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    case (idx)
      3'd0:    return mac[47:40];
      3'd1:    return mac[39:32];
      3'd2:    return mac[31:24];
      3'd3:    return mac[23:16];
      3'd4:    return mac[15:8];
      default: return mac[7:0];
    endcase
  endfunction

  // Byte idx of an IPv4 address in wire order (byte 0 is the MSB).
  function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] idx);
    case (idx)
      2'd0:    return ip[31:24];
      2'd1:    return ip[23:16];
      2'd2:    return ip[15:8];
      default: return ip[7:0];
    endcase
  endfunction

endpackage

// File: rtl/arp_rx.sv
// GMII ARP receiver: parses preamble, Ethernet header and ARP payload, and
// reports sender MAC/IP and opcode of each request/reply aimed at the board.
module arp_rx
  import arp_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd0, 8'd5}
) (
  input  logic        gmii_rxc,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic [47:0] pc_mac,
  output logic [31:0] pc_ip
);

  arp_state_e       state;
  logic [CNT_W-1:0] cnt_byte;
  logic             mac_ok;
  logic             bc_ok;
  logic             type_hi_ok;
  logic             op_rep;
  logic [47:0]      mac_shadow;
  logic [31:0]      ip_shadow;

  // Frame parser; outputs only move on a fully validated frame.
  always_ff @(posedge gmii_rxc or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt_byte    <= '0;
      mac_ok      <= 1'b0;
      bc_ok       <= 1'b0;
      type_hi_ok  <= 1'b0;
      op_rep      <= 1'b0;
      mac_shadow  <= '0;
      ip_shadow   <= '0;
      arp_rx_done <= 1'b0;
      arp_rx_type <= 1'b0;
      pc_mac      <= '0;
      pc_ip       <= '0;
    end else begin
      arp_rx_done <= 1'b0;
      if (!gmii_rx_dv && state != IDLE) begin
        state    <= IDLE;
        cnt_byte <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (gmii_rx_dv && gmii_rxd == PREAMBLE) begin
              state    <= PRE_DATA;
              cnt_byte <= CNT_W'(1);
            end
          end

          PRE_DATA: begin
            if (cnt_byte == CNT_W'(7)) begin
              state    <= (gmii_rxd == SFD) ? ETH_HEAD : RX_END;
              cnt_byte <= '0;
            end else if (gmii_rxd == PREAMBLE) begin
              cnt_byte <= cnt_byte + CNT_W'(1);
            end else begin
              state    <= RX_END;
              cnt_byte <= '0;
            end
          end

          ETH_HEAD: begin
            cnt_byte <= cnt_byte + CNT_W'(1);
            // Unicast and broadcast matches tracked as sticky flags over bytes 0..5.
            if (cnt_byte < CNT_W'(6)) begin
              mac_ok <= (gmii_rxd == mac_byte(BOARD_MAC, cnt_byte[2:0])) &&
                        (mac_ok || cnt_byte == '0);
              bc_ok  <= (gmii_rxd == 8'hFF) && (bc_ok || cnt_byte == '0);
            end
            if (cnt_byte == CNT_W'(12)) begin
              type_hi_ok <= (gmii_rxd == ETH_TYPE_ARP[15:8]);
            end
            if (cnt_byte == CNT_W'(13)) begin
              cnt_byte <= '0;
              if ((mac_ok || bc_ok) && type_hi_ok && gmii_rxd == ETH_TYPE_ARP[7:0]) begin
                state <= ARP_DATA;
              end else begin
                state <= RX_END;
              end
            end
          end

          ARP_DATA: begin
            cnt_byte <= cnt_byte + CNT_W'(1);
            if (cnt_byte < CNT_W'(7)) begin
              if (gmii_rxd != arp_hdr_byte(cnt_byte[2:0])) begin
                state    <= RX_END;
                cnt_byte <= '0;
              end
            end else if (cnt_byte == CNT_W'(7)) begin
              if (gmii_rxd == ARP_OP_REQ || gmii_rxd == ARP_OP_REP) begin
                op_rep <= (gmii_rxd == ARP_OP_REP);
              end else begin
                state    <= RX_END;
                cnt_byte <= '0;
              end
            end else if (cnt_byte < CNT_W'(14)) begin
              mac_shadow <= {mac_shadow[39:0], gmii_rxd};
            end else if (cnt_byte < CNT_W'(18)) begin
              ip_shadow <= {ip_shadow[23:0], gmii_rxd};
            end else if (cnt_byte >= CNT_W'(24)) begin
              // Target IP bytes 24..27: low two count bits index the address.
              if (gmii_rxd != ip_byte(BOARD_IP, cnt_byte[1:0])) begin
                state    <= RX_END;
                cnt_byte <= '0;
              end else if (cnt_byte == CNT_W'(27)) begin
                state       <= RX_END;
                cnt_byte    <= '0;
                pc_mac      <= mac_shadow;
                pc_ip       <= ip_shadow;
                arp_rx_type <= op_rep;
                arp_rx_done <= 1'b1;
              end
            end
          end

          RX_END: begin
            // Remain here through padding and FCS; dv low is handled above.
            cnt_byte <= '0;
          end

          default: begin
            state    <= IDLE;
            cnt_byte <= '0;
          end
        endcase
      end
    end
  end

endmodule
